// File: rtl/pc_pkg.sv
// Shared constants for the fetch-stage program-counter generator.
package pc_pkg;

  // Bytes per instruction; sequential fetch advances by this amount.
  localparam int INST_BYTES = 4;

  // 2-bit branch counter encodings.
  localparam logic [1:0] SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  // Default PC loaded on reset.
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational; training updates land on the clock edge, so a
// same-cycle lookup always sees the pre-update contents.
module pc_btb
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_hit,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [BTB_DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
  logic [TAG_W-1:0]     tag_d    [BTB_DEPTH];
  logic [XLEN-1:0]      target_q [BTB_DEPTH];
  logic [XLEN-1:0]      target_d [BTB_DEPTH];
  logic [1:0]           ctr_q    [BTB_DEPTH];
  logic [1:0]           ctr_d    [BTB_DEPTH];

  logic [IDX-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_offset;
  assign unused_offset = ^{lk_pc[1:0], upd_pc[1:0]};

  function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(INST_BYTES - 1);
  endfunction

  assign lk_idx    = lk_pc[IDX+1:2];
  assign lk_tag    = lk_pc[XLEN-1:IDX+2];
  assign upd_idx   = upd_pc[IDX+1:2];
  assign upd_tag   = upd_pc[XLEN-1:IDX+2];

  assign lk_hit    = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit & ctr_q[lk_idx][1];
  assign lk_target = target_q[lk_idx];
  assign upd_hit   = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

  // Training: train the counter on a hit, allocate on a taken miss.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_d[upd_idx]    = ctr_sat_inc(ctr_q[upd_idx]);
          target_d[upd_idx] = align(upd_target);
        end else begin
          ctr_d[upd_idx]    = ctr_sat_dec(ctr_q[upd_idx]);
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = align(upd_target);
        ctr_d[upd_idx]    = WT;
      end
    end
  end

  // Valid bits are the only reset state; reset wins over training.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Entry payload; meaningless while its valid bit is clear.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: PC register, request valid flag,
// next-PC selection and an embedded BTB for taken-branch prediction.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(DEFAULT_RESET_ADDR),
  parameter int              BTB_DEPTH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            pred_taken
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            adv;
  logic            lk_hit, lk_taken;
  logic [XLEN-1:0] lk_target;

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(INST_BYTES - 1);
  endfunction

  pc_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (pc_q),
    .lk_hit     (lk_hit),
    .lk_taken   (lk_taken),
    .lk_target  (lk_target),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken)
  );

  // Hit alone does not steer fetch; only the taken-prediction does.
  logic unused_hit;
  assign unused_hit = lk_hit;

  assign adv        = pc_valid_q & fetch_ready & ~stall;
  assign pred_taken = pc_valid_q & lk_taken;

  // Next-PC select: trap > redirect > hold > predicted target > sequential.
  always_comb begin
    pc_valid_d = 1'b1;
    pc_d       = pc_q;
    if (trap)            pc_d = align(trap_vec);
    else if (redirect)   pc_d = align(redirect_addr);
    else if (!adv)       pc_d = pc_q;
    else if (pred_taken) pc_d = align(lk_target);
    else                 pc_d = pc_q + XLEN'(INST_BYTES);
  end

  // PC and request-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_ADDR;
      pc_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen with hand-computed expected values.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, fetch_ready, trap, redirect;
  logic        upd_en, upd_taken;
  logic [31:0] trap_vec, redirect_addr, upd_pc, upd_target;
  logic [31:0] pc;
  logic        pc_valid, pred_taken;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN       (32),
    .RESET_ADDR (32'h0000_0000),
    .BTB_DEPTH  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .fetch_ready   (fetch_ready),
    .trap          (trap),
    .trap_vec      (trap_vec),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .upd_en        (upd_en),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .pred_taken    (pred_taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    step();
    redirect      = 1'b0;
  endtask

  task automatic train(input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_en     = 1'b1;
    upd_pc     = p;
    upd_target = t;
    upd_taken  = tk;
    step();
    upd_en     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; fetch_ready = 1'b0; trap = 1'b0; redirect = 1'b0;
    upd_en = 1'b0; upd_taken = 1'b0;
    trap_vec = '0; redirect_addr = '0; upd_pc = '0; upd_target = '0;

    // Reset and sequential fetch
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'd0);
    rst = 1'b0; fetch_ready = 1'b1;
    step();
    check("first_pc", pc, 32'h0);
    check("first_valid", {31'b0, pc_valid}, 32'd1);
    step(); check("seq_4", pc, 32'h4);
    step(); check("seq_8", pc, 32'h8);

    // Hold under stall, then under fetch_ready=0
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); check("stall_hold", pc, 32'h8); end
    stall = 1'b0; fetch_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin step(); check("nrdy_hold", pc, 32'h8); end
    fetch_ready = 1'b1;
    step(); check("seq_c", pc, 32'hC);

    // Redirect beats stall; trap beats redirect; addresses aligned
    stall = 1'b1;
    redirect_to(32'h103);
    check("redir_stall", pc, 32'h100);
    check("redir_valid", {31'b0, pc_valid}, 32'd1);
    stall = 1'b0;
    trap = 1'b1; trap_vec = 32'h80; redirect = 1'b1; redirect_addr = 32'h200;
    step();
    trap = 1'b0; redirect = 1'b0;
    check("trap_prio", pc, 32'h80);

    // Allocate taken entry at 0x10, then predict it
    train(32'h10, 32'h40, 1'b1);
    check("train_adv", pc, 32'h84);
    redirect_to(32'h10);
    check("pred_hit", {31'b0, pred_taken}, 32'd1);
    step(); check("pred_target", pc, 32'h40);

    // Two not-taken updates: WT -> WNT -> SNT
    train(32'h10, 32'h40, 1'b0);
    train(32'h10, 32'h40, 1'b0);
    redirect_to(32'h10);
    check("nt_pred", {31'b0, pred_taken}, 32'd0);
    step(); check("nt_seq", pc, 32'h14);

    // Back up to WT, then alias check at 0x30 (same index, other tag)
    train(32'h10, 32'h40, 1'b1);
    train(32'h10, 32'h40, 1'b1);
    redirect_to(32'h30);
    check("alias_miss", {31'b0, pred_taken}, 32'd0);
    step(); check("alias_seq", pc, 32'h34);
    train(32'h30, 32'h60, 1'b0);
    redirect_to(32'h10);
    check("alias_keep", {31'b0, pred_taken}, 32'd1);
    step(); check("alias_keep_tgt", pc, 32'h40);

    // Taken miss at 0x30 overwrites the aliasing entry
    train(32'h30, 32'h62, 1'b1);
    redirect_to(32'h30);
    check("ovw_pred", {31'b0, pred_taken}, 32'd1);
    step(); check("ovw_tgt", pc, 32'h60);
    redirect_to(32'h10);
    check("ovw_evict", {31'b0, pred_taken}, 32'd0);

    // Wrap-around of sequential increment
    redirect_to(32'hFFFF_FFFC);
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    step(); check("wrap", pc, 32'h0);

    // Reset mid-operation while training; BTB must be emptied
    redirect_to(32'h30);
    rst = 1'b1;
    train(32'h20, 32'h50, 1'b1);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_valid", {31'b0, pc_valid}, 32'd0);
    rst = 1'b0;
    step();
    check("mid_rel_valid", {31'b0, pc_valid}, 32'd1);
    redirect_to(32'h30);
    check("rst_clear_30", {31'b0, pred_taken}, 32'd0);
    step(); check("rst_clear_seq", pc, 32'h34);

    // Same-cycle update and lookup: lookup sees old contents
    redirect_to(32'h10);
    upd_en = 1'b1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1'b1;
    #1;
    check("same_cyc_pred", {31'b0, pred_taken}, 32'd0);
    step();
    upd_en = 1'b0;
    check("same_cyc_seq", pc, 32'h14);
    redirect_to(32'h20);
    check("rst_upd_dropped", {31'b0, pred_taken}, 32'd0);
    step(); check("rst_upd_seq", pc, 32'h24);
    redirect_to(32'h10);
    check("late_pred", {31'b0, pred_taken}, 32'd1);
    step(); check("late_tgt", pc, 32'h40);

    // Update concurrent with redirect: both take effect
    upd_en = 1'b1; upd_pc = 32'h18; upd_target = 32'h70; upd_taken = 1'b1;
    redirect_to(32'h200);
    upd_en = 1'b0;
    check("upd_redir_pc", pc, 32'h200);
    redirect_to(32'h18);
    check("upd_redir_pred", {31'b0, pred_taken}, 32'd1);
    step(); check("upd_redir_tgt", pc, 32'h70);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage.
- Holds the current fetch PC and presents it with a valid/ready handshake to instruction memory.
- Selects the next PC from reset vector, trap vector, execute-stage redirect, a BTB prediction, or sequential +4.
- Contains a direct-mapped branch target buffer (BTB) with 2-bit counters, trained by the execute stage.

Parameters:
- XLEN, 32, address/data width.
- RESET_ADDR, 32'h0000_0000, PC loaded on reset.
- BTB_DEPTH, 8, BTB entries; power of 2, minimum 2. IDX = log2(BTB_DEPTH).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold PC (pipeline back-pressure).
- fetch_ready  in  1  instruction memory accepts the current PC.
- trap  in  1  take trap.
- trap_vec  in  XLEN  trap target.
- redirect  in  1  execute-stage correction (jump/mispredict).
- redirect_addr  in  XLEN  correction target.
- upd_en  in  1  BTB training strobe.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_target  in  XLEN  resolved target.
- upd_taken  in  1  branch was taken.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- pred_taken  out  1  BTB predicts the current pc taken.

Behaviour:
- Reset (rst=1 at posedge):
  - pc <= RESET_ADDR; pc_valid <= 0.
  - All BTB valid bits cleared.
  - Overrides every other input, including upd_en.
  - In the first cycle after rst deasserts: pc_valid=1 and pc=RESET_ADDR.
- Handshake:
  - A fetch is accepted when pc_valid & fetch_ready & ~stall (adv).
  - While pc_valid=1 the pc is held stable until adv, trap or redirect.
- Next-PC priority, evaluated each posedge:
  - rst
  - trap -> trap_vec
  - redirect -> redirect_addr
  - !adv -> hold pc
  - adv & pred_taken -> BTB target
  - adv -> pc + 4
- trap and redirect:
  - Take effect at the next edge regardless of stall or fetch_ready.
  - The unaccepted request is abandoned; downstream flushing is the pipeline's responsibility.
  - pc_valid stays 1.
- Alignment: every loaded address (trap_vec, redirect_addr, BTB target) has bits [1:0] forced to 0, so pc[1:0] is always 0.
- Arithmetic: pc + 4 is computed modulo 2^XLEN; 0xFFFF_FFFC + 4 wraps to 0x0.
- BTB entry fields: valid, tag, target[XLEN-1:0], ctr[1:0].
  - index = addr[IDX+1:2]; tag = addr[XLEN-1:IDX+2].
- BTB lookup: combinational on pc.
  - hit = valid & tag match.
  - pred_taken = pc_valid & hit & ctr[1].
- BTB update, on the edge where upd_en=1 (and rst=0):
  - Hit at upd_pc, upd_taken=1: ctr saturating increment (max 2'b11); target <= upd_target.
  - Hit at upd_pc, upd_taken=0: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss and upd_taken=1: allocate/overwrite the entry; valid=1, tag, target, ctr=2'b10 (weakly taken).
  - Miss and upd_taken=0: no change.
- Simultaneous update and lookup on the same index: the lookup uses the pre-update contents; the new contents are visible from the next cycle.
- Simultaneous upd_en with redirect or trap: both take effect. The BTB update does not alter the redirect target.

Decomposition:
- Shared package (pc_pkg):
  - INST_BYTES = 4.
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Default RESET_ADDR constant.
- One sub-module, pc_btb: storage array plus lookup and update logic. Parameters XLEN and BTB_DEPTH.
  - Lookup interface: lk_pc -> lk_hit, lk_taken, lk_target.
  - Update interface: upd_*.
- pc_gen keeps the PC register, valid flag and next-PC mux.

Test Plan:
- Reset/sequential: rst=1 for 2 cycles -> pc=0x0, pc_valid=0. Release with fetch_ready=1 -> pc_valid=1, pc sequence 0x0, 0x4, 0x8, 0xC.
- Hold: at pc=0x8, stall=1 for 3 cycles -> pc stays 0x8. Then stall=0, fetch_ready=0 for 2 cycles -> still 0x8. fetch_ready=1 -> 0xC.
- Priority: stall=1 with redirect=1, redirect_addr=0x103 -> next pc=0x100. trap=1 (trap_vec=0x80) together with redirect=1 (addr 0x200) -> next pc=0x80.
- BTB train/predict:
  - upd_en with upd_pc=0x10, upd_target=0x40, upd_taken=1; then redirect to 0x10 -> pred_taken=1, next pc=0x40.
  - Two not-taken updates at 0x10 (ctr 10->01->00) -> at pc=0x10, pred_taken=0, next pc=0x14.
- Aliasing (BTB_DEPTH=8): entry allocated for 0x10; lookup at 0x30 (same index, different tag) -> miss, next pc=0x34. Not-taken update at 0x30 leaves the 0x10 entry intact.
- Wrap and reset mid-operation:
  - redirect_addr=0xFFFF_FFFC, then adv -> pc=0x0.
  - rst asserted while upd_en=1 -> pc=RESET_ADDR and BTB empty; later lookup of that upd_pc misses.
